// File: rtl/seg_display_converter.sv
// Binary to seven-segment converter: sequential double-dabble for decimal,
// plain nibble split for hex, with leading-zero blanking and overflow dashes.
module seg_display_converter #(
  parameter int WIDTH      = 10,
  parameter int NUM_DIGITS = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [WIDTH-1:0]             value,
  input  logic                         hex_mode,
  input  logic                         blank_zeros,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow,
  output logic [NUM_DIGITS-1:0][6:0]   HEX
);

  // Decimal needs ceil(WIDTH/3) nibbles; hex needs fewer, so one sizing covers both.
  localparam int ACC_D = (WIDTH + 2) / 3;
  localparam int ACC_W = 4 * ACC_D;
  localparam int MAXD  = (ACC_D > NUM_DIGITS) ? ACC_D : NUM_DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD_OUT} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_sh;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_hex_mode;
  logic               r_blank;

  logic [ACC_W-1:0]                 w_adj;
  logic [ACC_W-1:0]                 w_next_acc;
  logic [4*MAXD-1:0]                w_ext;
  logic                             w_ovf;
  logic [NUM_DIGITS-1:0][6:0]       w_hex;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'h0: f_seg = 7'b1000000;
      4'h1: f_seg = 7'b1111001;
      4'h2: f_seg = 7'b0100100;
      4'h3: f_seg = 7'b0110000;
      4'h4: f_seg = 7'b0011001;
      4'h5: f_seg = 7'b0010010;
      4'h6: f_seg = 7'b0000010;
      4'h7: f_seg = 7'b1111000;
      4'h8: f_seg = 7'b0000000;
      4'h9: f_seg = 7'b0010000;
      4'hA: f_seg = 7'b0001000;
      4'hB: f_seg = 7'b0000011;
      4'hC: f_seg = 7'b1000110;
      4'hD: f_seg = 7'b0100001;
      4'hE: f_seg = 7'b0000110;
      default: f_seg = 7'b0001110;
    endcase
  endfunction

  // One double-dabble step: add 3 to nibbles >= 5 (decimal only), then shift in next MSB.
  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < ACC_D; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
    end
    w_next_acc = r_hex_mode ? {r_acc[ACC_W-2:0], r_sh[WIDTH-1]}
                            : {w_adj[ACC_W-2:0], r_sh[WIDTH-1]};
  end

  // Final digit decode: overflow check on digits past the display, then blanking from the top down.
  always_comb begin
    logic lead;
    w_ext = '0;
    w_ext[ACC_W-1:0] = r_acc;
    w_ovf = 1'b0;
    for (int i = NUM_DIGITS; i < MAXD; i++) begin
      if (w_ext[4*i +: 4] != 4'd0) w_ovf = 1'b1;
    end
    lead  = 1'b1;
    w_hex = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lead = lead && (w_ext[4*i +: 4] == 4'd0);
      if (w_ovf)                          w_hex[i] = SEG_DASH;
      else if (r_blank && lead && i != 0) w_hex[i] = SEG_BLANK;
      else                                w_hex[i] = f_seg(w_ext[4*i +: 4]);
    end
  end

  // Control FSM with registered outputs; HEX/overflow hold between conversions.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_sh       <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_hex_mode <= 1'b0;
      r_blank    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      HEX        <= {NUM_DIGITS{SEG_ZERO}};
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_sh       <= value;
            r_hex_mode <= hex_mode;
            r_blank    <= blank_zeros;
            r_acc      <= '0;
            r_cnt      <= '0;
            busy       <= 1'b1;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_acc <= w_next_acc;
          r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= LOAD_OUT;
        end
        LOAD_OUT: begin
          HEX      <= w_hex;
          overflow <= w_ovf;
          done     <= 1'b1;
          busy     <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_converter.sv
// Bench for seg_display_converter: transaction-level model checked every cycle,
// plus directed literal checks on latency, codes, blanking, overflow and reset abort.
module tb_seg_display_converter;
  localparam int W  = 10;
  localparam int ND = 3;

  typedef logic [ND-1:0][6:0] hex_t;

  logic clk = 1'b0;
  logic reset, start, hex_mode, blank_zeros;
  logic [W-1:0] value;
  logic busy, done, overflow;
  hex_t HEX;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  seg_display_converter #(.WIDTH(W), .NUM_DIGITS(ND)) dut (
    .clk(clk), .reset(reset), .start(start), .value(value),
    .hex_mode(hex_mode), .blank_zeros(blank_zeros),
    .busy(busy), .done(done), .overflow(overflow), .HEX(HEX)
  );

  always #5 clk = ~clk;

  // Display glyphs indexed by digit value.
  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // What the display must show for a value, from plain radix arithmetic.
  function automatic hex_t expect_hex(input int v, input bit h, input bit b, output bit ovf);
    int radix, lim, msd;
    int dig [ND];
    hex_t r;
    radix = h ? 16 : 10;
    lim = 1;
    for (int i = 0; i < ND; i++) lim = lim * radix;
    ovf = (v >= lim);
    msd = 0;
    for (int i = 0; i < ND; i++) begin
      dig[i] = v % radix;
      v = v / radix;
      if (dig[i] != 0) msd = i;
    end
    for (int i = 0; i < ND; i++) begin
      if (ovf)                 r[i] = 7'b0111111;
      else if (b && i > msd)   r[i] = 7'b1111111;
      else                     r[i] = seg_tab[dig[i]];
    end
    return r;
  endfunction

  // Transaction model: a conversion accepted now completes WIDTH+1 edges later.
  bit   m_busy, m_done, m_ovf;
  hex_t m_hex;
  int   m_left, m_val;
  bit   m_h, m_b;
  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_ovf = 0; m_left = 0;
      m_hex = {ND{7'b1000000}};
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1;
          m_hex = expect_hex(m_val, m_h, m_b, m_ovf);
        end
      end else if (start) begin
        m_val = int'(value); m_h = hex_mode; m_b = blank_zeros;
        m_busy = 1; m_left = W + 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (busy !== m_busy || done !== m_done || overflow !== m_ovf || HEX !== m_hex) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t dut busy=%b done=%b ovf=%b hex=%h, model busy=%b done=%b ovf=%b hex=%h",
                 $time, busy, done, overflow, HEX, m_busy, m_done, m_ovf, m_hex);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Launch one conversion and return the number of edges until done is seen.
  task automatic convert(input int v, input bit h, input bit b, output int lat);
    value = W'(v); hex_mode = h; blank_zeros = b; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1 lat++;
      if (done) break;
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL done_timeout value=%0d waited=%0d expected=%0d", v, lat, W + 1);
    end
  endtask

  initial begin
    int lat, n, gap;
    bit o;
    hex_t e;
    reset = 1; start = 0; value = '0; hex_mode = 0; blank_zeros = 0;

    // Pin the model on hand-computed cases.
    e = expect_hex(123, 0, 0, o);
    chk("model_123", {o, e}, {1'b0, 7'b1111001, 7'b0100100, 7'b0110000});
    e = expect_hex(7, 0, 1, o);
    chk("model_7_blank", {o, e}, {1'b0, 7'b1111111, 7'b1111111, 7'b1111000});
    e = expect_hex(1000, 0, 1, o);
    chk("model_1000", {o, e}, {1'b1, 7'b0111111, 7'b0111111, 7'b0111111});

    repeat (3) @(posedge clk);
    #2 reset = 0;
    #1 chk("reset_state", {busy, done, overflow, HEX}, {3'b000, 7'b1000000, 7'b1000000, 7'b1000000});
    cmp_en = 1'b1;

    convert(123, 0, 0, lat);
    chk("lat_123", lat, W + 1);
    chk("hex_123", {done, busy, overflow, HEX}, {3'b100, 7'b1111001, 7'b0100100, 7'b0110000});
    @(posedge clk); #1 chk("done_one_cycle", done, 0);

    convert(7, 0, 1, lat);
    chk("hex_7_blank", HEX, {7'b1111111, 7'b1111111, 7'b1111000});
    convert(0, 0, 1, lat);
    chk("hex_0_blank", HEX, {7'b1111111, 7'b1111111, 7'b1000000});
    convert(1000, 0, 1, lat);
    chk("ovf_1000", {overflow, HEX}, {1'b1, 7'b0111111, 7'b0111111, 7'b0111111});
    convert(999, 0, 0, lat);
    chk("hex_999", {overflow, HEX}, {1'b0, 7'b0010000, 7'b0010000, 7'b0010000});
    convert('h3AF, 1, 0, lat);
    chk("lat_hex", lat, W + 1);
    chk("hex_3AF", {overflow, HEX}, {1'b0, 7'b0110000, 7'b0001000, 7'b0001110});

    // A second start mid-conversion is ignored.
    value = W'(123); hex_mode = 0; blank_zeros = 0; start = 1;
    @(posedge clk); #2 start = 0;
    repeat (2) @(posedge clk);
    #2 value = W'(456); start = 1;
    @(posedge clk); #2 start = 0; value = '0;
    n = 0;
    while (n < 40) begin @(posedge clk); #1 n++; if (done) break; end
    chk("ignore_start", HEX, {7'b1111001, 7'b0100100, 7'b0110000});

    // Start held high: done recurs every WIDTH+2 cycles.
    @(posedge clk); #2 value = W'(555); start = 1;
    n = 0;
    while (n < 40) begin @(posedge clk); #1 n++; if (done) break; end
    gap = 0;
    while (gap < 40) begin @(posedge clk); #1 gap++; if (done) break; end
    chk("done_period", gap, W + 2);
    #1 start = 0;

    // Reset at cycle 5 of a conversion aborts it.
    while (busy) @(posedge clk);
    #2 value = W'(321); start = 1;
    @(posedge clk); #2 start = 0;
    repeat (4) @(posedge clk);
    #2 reset = 1;
    @(posedge clk); #1 chk("abort_state", {busy, done, overflow, HEX},
                           {3'b000, 7'b1000000, 7'b1000000, 7'b1000000});
    #1 reset = 0;
    n = 0;
    repeat (15) begin @(posedge clk); #1 if (done) n++; end
    chk("abort_no_done", n, 0);

    // Random traffic, including starts while busy and occasional resets.
    repeat (1500) begin
      @(posedge clk); #2;
      start       = ($urandom_range(0, 3) == 0);
      value       = W'($urandom);
      hex_mode    = $urandom_range(0, 1);
      blank_zeros = $urandom_range(0, 1);
      reset       = ($urandom_range(0, 199) == 0);
    end
    #2 reset = 0; start = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
